// File: rtl/fetch_queue_if.sv
// Bundle of the fetch stage's instruction-memory handshake, redirect/stall
// controls and the IF/ID-facing outputs. The fetch unit uses the master
// modport; memory, hazard unit and IF/ID register see the slave side.
interface fetch_queue_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a prefetch queue in front of IF/ID.
// Owns the fetch PC, issues word requests over a req/ack handshake, buffers
// returned instructions with their PCs, drains them under the hazard stall
// and flushes on redirect. A request is only issued when a queue slot is
// free, so an in-flight response can always be stored.
// Optional feature: define FETCH_BYPASS_EN to forward an ack straight to
// the IF/ID outputs when the queue is empty (zero-cycle fetch latency).
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       fetch_pc_q, fetch_pc_d;
    logic [63:0]       addr_q, addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       instr_d [DEPTH];
    logic [63:0]       pc_q [DEPTH];
    logic [63:0]       pc_d [DEPTH];

    logic        redirect;
    logic [63:0] redirect_aligned;
    logic        ack_fire;
    logic        bypass;
    logic        push;
    logic        pop;

    // Decode this cycle's events; redirect outranks push and stall.
    always_comb begin
        redirect         = bus.redirect_valid;
        redirect_aligned = bus.redirect_pc & ~64'h3;
        ack_fire         = (state_q == REQ) && bus.imem_ack;
`ifdef FETCH_BYPASS_EN
        bypass           = ack_fire && !redirect && (count_q == '0) && !bus.stall;
`else
        bypass           = 1'b0;
`endif
        push             = ack_fire && !redirect && !bypass;
        pop              = (count_q != '0) && !bus.stall && !redirect;
    end

    // Queue storage, pointers and occupancy; a redirect empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                instr_d[tail_q] = bus.imem_rdata;
                pc_d[tail_q]    = addr_q;
                tail_d          = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Request FSM; the request address is frozen while a stale request drains.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    state_d    = REQ;
                end else if (count_q < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    state_d    = bus.imem_ack ? REQ : DISCARD;
                end else if (bus.imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = (count_d < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                end
                if (bus.imem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        addr_d = (state_d == DISCARD) ? addr_q : fetch_pc_d;
    end

    // Drive memory request and IF/ID outputs; NOP with PC 0 when nothing is valid.
    always_comb begin
        bus.imem_req  = (state_q != IDLE);
        bus.imem_addr = addr_q;
        bus.if_valid  = 1'b0;
        bus.if_instr  = NOP;
        bus.if_pc     = 64'h0;
        if (count_q != '0) begin
            bus.if_valid = 1'b1;
            bus.if_instr = instr_q[head_q];
            bus.if_pc    = pc_q[head_q];
        end else if (bypass) begin
            bus.if_valid = 1'b1;
            bus.if_instr = bus.imem_rdata;
            bus.if_pc    = addr_q;
        end
    end

    // State registers with asynchronous reset back to an empty, idle fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, RESET_PC=0).
// Memory returns addr[31:0]^addr[63:32]^32'hC0DE0000 for each word; ack is
// either tied to imem_req (zero-wait) or driven by hand.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;
    logic zero_wait;
    logic manual_ack;
    int   total;
    int   bad;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE0000;
    endfunction

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: ack either follows req or is hand-driven.
    always_comb begin
        bus.imem_ack   = zero_wait ? bus.imem_req : manual_ack;
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset(input logic st, input logic zw);
        rst = 1'b1;
        bus.stall = st;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        zero_wait = zw;
        manual_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        zero_wait = 1'b0;
        manual_ack = 1'b0;
        #2;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0h want 0", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("[TB] FAIL reset_addr: got %0h want 0", bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0h want 0", bus.if_valid); end
        total++; if (bus.if_instr !== NOP) begin bad++; $display("[TB] FAIL reset_instr: got %0h want %0h", bus.if_instr, NOP); end
        total++; if (bus.if_pc !== 64'h0) begin bad++; $display("[TB] FAIL reset_pc: got %0h want 0", bus.if_pc); end
    endtask

    task automatic test_stream();
        do_reset(1'b0, 1'b1);
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL stream_first_req: got %0h want 1", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("[TB] FAIL stream_first_addr: got %0h want 0", bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_first_valid: got %0h want 0", bus.if_valid); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++; if (bus.imem_addr !== 64'(4 * i)) begin bad++; $display("[TB] FAIL stream_addr[%0d]: got %0h want %0h", i, bus.imem_addr, 4 * i); end
            total++; if (bus.if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid[%0d]: got %0h want 1", i, bus.if_valid); end
            total++; if (bus.if_pc !== 64'(4 * (i - 1))) begin bad++; $display("[TB] FAIL stream_pc[%0d]: got %0h want %0h", i, bus.if_pc, 4 * (i - 1)); end
            total++; if (bus.if_instr !== mem_word(64'(4 * (i - 1)))) begin bad++; $display("[TB] FAIL stream_instr[%0d]: got %0h want %0h", i, bus.if_instr, mem_word(64'(4 * (i - 1)))); end
        end
    endtask

    task automatic test_stall_fill();
        do_reset(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req_drop: got %0h want 0", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h10) begin bad++; $display("[TB] FAIL stall_next_addr: got %0h want 10", bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid: got %0h want 1", bus.if_valid); end
        total++; if (bus.if_pc !== 64'h0) begin bad++; $display("[TB] FAIL stall_head_pc: got %0h want 0", bus.if_pc); end
        bus.stall = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++; if (bus.if_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_valid[%0d]: got %0h want 1", i, bus.if_valid); end
            total++; if (bus.if_pc !== 64'(4 * i)) begin bad++; $display("[TB] FAIL drain_pc[%0d]: got %0h want %0h", i, bus.if_pc, 4 * i); end
        end
    endtask

    task automatic test_slow_memory();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                total++; if (bus.imem_addr !== 64'(4 * i)) begin bad++; $display("[TB] FAIL slow_addr[%0d.%0d]: got %0h want %0h", i, w, bus.imem_addr, 4 * i); end
                total++; if (bus.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL slow_req[%0d.%0d]: got %0h want 1", i, w, bus.imem_req); end
                if (w == 0 && i > 0) begin
                    total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'(4 * (i - 1))) begin bad++; $display("[TB] FAIL slow_deliver[%0d]: got valid=%0h pc=%0h want valid=1 pc=%0h", i, bus.if_valid, bus.if_pc, 4 * (i - 1)); end
                end else begin
                    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL slow_gap[%0d.%0d]: got %0h want 0", i, w, bus.if_valid); end
                end
                manual_ack = (w == 2);
            end
        end
        @(negedge clk);
        manual_ack = 1'b0;
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h8) begin bad++; $display("[TB] FAIL slow_last: got valid=%0h pc=%0h want valid=1 pc=8", bus.if_valid, bus.if_pc); end
    endtask

    task automatic test_redirect_discard();
        do_reset(1'b0, 1'b0);
        @(negedge clk);
        manual_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.imem_addr !== 64'h8 || bus.if_pc !== 64'h4) begin bad++; $display("[TB] FAIL disc_setup: got addr=%0h pc=%0h want addr=8 pc=4", bus.imem_addr, bus.if_pc); end
        manual_ack = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("[TB] FAIL disc_req_hold: got %0h want 1", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h8) begin bad++; $display("[TB] FAIL disc_addr_hold1: got %0h want 8", bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL disc_flush: got %0h want 0", bus.if_valid); end
        @(negedge clk);
        total++; if (bus.imem_addr !== 64'h8) begin bad++; $display("[TB] FAIL disc_addr_hold2: got %0h want 8", bus.imem_addr); end
        manual_ack = 1'b1;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin bad++; $display("[TB] FAIL disc_new_req: got req=%0h addr=%0h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL disc_stale_dropped: got %0h want 0", bus.if_valid); end
        @(negedge clk);
        manual_ack = 1'b0;
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h100) begin bad++; $display("[TB] FAIL disc_first_pc: got valid=%0h pc=%0h want valid=1 pc=100", bus.if_valid, bus.if_pc); end
        total++; if (bus.if_instr !== mem_word(64'h100)) begin bad++; $display("[TB] FAIL disc_first_instr: got %0h want %0h", bus.if_instr, mem_word(64'h100)); end
    endtask

    task automatic test_redirect_with_ack();
        do_reset(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0 || bus.imem_addr !== 64'h8) begin bad++; $display("[TB] FAIL rack_setup: got valid=%0h pc=%0h addr=%0h want 1/0/8", bus.if_valid, bus.if_pc, bus.imem_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("[TB] FAIL rack_flush: got %0h want 0", bus.if_valid); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) begin bad++; $display("[TB] FAIL rack_new_addr: got req=%0h addr=%0h want req=1 addr=200", bus.imem_req, bus.imem_addr); end
        bus.stall = 1'b0;
        @(negedge clk);
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h200) begin bad++; $display("[TB] FAIL rack_first_pc: got valid=%0h pc=%0h want valid=1 pc=200", bus.if_valid, bus.if_pc); end
        total++; if (bus.if_instr !== mem_word(64'h200)) begin bad++; $display("[TB] FAIL rack_first_instr: got %0h want %0h", bus.if_instr, mem_word(64'h200)); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        zero_wait = 1'b0;
        manual_ack = 1'b0;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'hC || bus.if_valid !== 1'b1) begin bad++; $display("[TB] FAIL arst_setup: got req=%0h addr=%0h valid=%0h want 1/c/1", bus.imem_req, bus.imem_addr, bus.if_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("[TB] FAIL arst_req: got %0h want 0", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("[TB] FAIL arst_addr: got %0h want 0", bus.imem_addr); end
        total++; if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP || bus.if_pc !== 64'h0) begin bad++; $display("[TB] FAIL arst_if: got valid=%0h instr=%0h pc=%0h want 0/13/0", bus.if_valid, bus.if_instr, bus.if_pc); end
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        zero_wait = 1'b1;
        @(negedge clk);
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin bad++; $display("[TB] FAIL arst_restart: got req=%0h addr=%0h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0 || bus.imem_addr !== 64'h4) begin bad++; $display("[TB] FAIL arst_refetch: got valid=%0h pc=%0h addr=%0h want 1/0/4", bus.if_valid, bus.if_pc, bus.imem_addr); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_stream();
        test_stall_fill();
        test_slow_memory();
        test_redirect_discard();
        test_redirect_with_ack();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
